// File: rtl/if_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int STALL_IF = 0;
  localparam int STALL_ID = 1;
  localparam int STALL_EX = 2;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic Stop        = 1'b1;
  localparam logic NoStop      = 1'b0;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_HOLD = 2'd2,
    IF_DROP = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush and stall handling with bubble insertion.
module if_fetch_stage_if_id_reg #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_id_i,
  input  logic              stall_ex_i,
  input  logic              new_valid_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic [INST_W-1:0] new_inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
);

  logic [ADDR_W-1:0] id_pc_q;
  logic [INST_W-1:0] id_inst_q;

  // ID stalled with EX running means ID's instruction moved on: insert a bubble.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      id_pc_q   <= '0;
      id_inst_q <= NOP_INST;
    end else if (stall_id_i && !stall_ex_i) begin
      id_pc_q   <= '0;
      id_inst_q <= NOP_INST;
    end else if (stall_id_i) begin
      id_pc_q   <= id_pc_q;
      id_inst_q <= id_inst_q;
    end else if (new_valid_i) begin
      id_pc_q   <= new_pc_i;
      id_inst_q <= new_inst_i;
    end else begin
      id_pc_q   <= '0;
      id_inst_q <= NOP_INST;
    end
  end

  assign id_pc_o   = id_pc_q;
  assign id_inst_o = id_inst_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request, response buffer when ID
// is stalled, and a PC-freeze request until each instruction reaches IF/ID.
module if_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = if_fetch_pkg::NOP_INST[INST_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ce,
  input  logic [5:0]        stall,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              stallreq_if,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
);
  import if_fetch_pkg::*;

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q;
  logic [ADDR_W-1:0] buf_pc_q;
  logic [INST_W-1:0] buf_inst_q;

  logic              id_may_load;
  logic              accept;
  logic              buf_store;
  logic              buf_clear;
  logic              new_valid;
  logic [ADDR_W-1:0] new_pc;
  logic [INST_W-1:0] new_inst;
  logic              unused_stall;

  assign unused_stall = ^{stall[5:3], stall[STALL_IF]};
  assign id_may_load  = !flush && (stall[STALL_ID] == NoStop);

  assign imem_req  = !rst && (state_q == IF_IDLE) && (ce == ChipEnable) && !flush;
  assign imem_addr = pc;
  assign accept    = (state_q == IF_IDLE) && (ce == ChipEnable) && imem_gnt;

  always_comb begin
    state_d   = state_q;
    buf_store = 1'b0;
    buf_clear = 1'b0;
    new_valid = 1'b0;
    new_pc    = req_pc_q;
    new_inst  = imem_rdata;
    case (state_q)
      IF_IDLE: begin
        // A grant means the request is in flight even if a flush arrives with it.
        if (accept) state_d = flush ? IF_DROP : IF_WAIT;
      end
      IF_WAIT: begin
        if (imem_rvalid) begin
          if (flush) begin
            state_d = IF_IDLE;
          end else if (id_may_load) begin
            new_valid = 1'b1;
            state_d   = IF_IDLE;
          end else begin
            buf_store = 1'b1;
            state_d   = IF_HOLD;
          end
        end else if (flush) begin
          state_d = IF_DROP;
        end
      end
      IF_HOLD: begin
        new_pc   = buf_pc_q;
        new_inst = buf_inst_q;
        if (flush) begin
          buf_clear = 1'b1;
          state_d   = IF_IDLE;
        end else if (id_may_load) begin
          new_valid = 1'b1;
          state_d   = IF_IDLE;
        end
      end
      IF_DROP: begin
        if (imem_rvalid) state_d = IF_IDLE;
      end
      default: state_d = IF_IDLE;
    endcase
  end

  assign stallreq_if = (ce == ChipEnable) && !new_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IF_IDLE;
      req_pc_q   <= '0;
      buf_pc_q   <= '0;
      buf_inst_q <= NOP_INST;
    end else begin
      state_q <= state_d;
      if (accept) req_pc_q <= pc;
      if (buf_store) begin
        buf_pc_q   <= req_pc_q;
        buf_inst_q <= imem_rdata;
      end else if (buf_clear) begin
        buf_pc_q   <= '0;
        buf_inst_q <= NOP_INST;
      end
    end
  end

  if_fetch_stage_if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .stall_id_i (stall[STALL_ID]),
    .stall_ex_i (stall[STALL_EX]),
    .new_valid_i(new_valid),
    .new_pc_i   (new_pc),
    .new_inst_i (new_inst),
    .id_pc_o    (id_pc),
    .id_inst_o  (id_inst)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed scenarios plus a randomized run against a transaction-level reference model.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stallreq_if;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .ce         (ce),
    .stall      (stall),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .stallreq_if(stallreq_if),
    .id_pc      (id_pc),
    .id_inst    (id_inst)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one in-flight fetch (possibly doomed by flush) and a parked response.
  bit          m_inflight, m_doomed;
  logic [31:0] m_fetch_pc;
  logic [63:0] m_parked[$];
  logic [31:0] m_id_pc, m_id_inst;

  task automatic model_reset();
    m_inflight = 0;
    m_doomed   = 0;
    m_parked.delete();
    m_id_pc    = 0;
    m_id_inst  = NOP;
  endtask

  function automatic bit model_idle();
    return !m_inflight && m_parked.size() == 0;
  endfunction

  function automatic bit model_delivers(output logic [31:0] dpc, output logic [31:0] dinst);
    bit may = !flush && !stall[1];
    dpc = 0;
    dinst = NOP;
    if (m_parked.size() != 0 && may) begin
      dpc = m_parked[0][63:32];
      dinst = m_parked[0][31:0];
      return 1;
    end
    if (m_inflight && !m_doomed && imem_rvalid && may) begin
      dpc = m_fetch_pc;
      dinst = imem_rdata;
      return 1;
    end
    return 0;
  endfunction

  task automatic model_clock();
    logic [31:0] dpc, dinst;
    bit del = model_delivers(dpc, dinst);
    if (flush || (stall[1] && !stall[2])) begin
      m_id_pc = 0; m_id_inst = NOP;
    end else if (!stall[1]) begin
      m_id_pc = del ? dpc : 32'h0;
      m_id_inst = del ? dinst : NOP;
    end
    if (m_parked.size() != 0) begin
      if (flush || del) m_parked.delete();
    end else if (m_inflight) begin
      if (imem_rvalid) begin
        m_inflight = 0;
        if (!m_doomed && !flush && !del) m_parked.push_back({m_fetch_pc, imem_rdata});
        m_doomed = 0;
      end else if (flush) begin
        m_doomed = 1;
      end
    end else if (ce && imem_gnt) begin
      m_inflight = 1;
      m_doomed = flush;
      m_fetch_pc = pc;
    end
  endtask

  task automatic test_reset();
    rst = 1; ce = 1; pc = 0; stall = 0; flush = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    cyc(); cyc();
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    n_checks++;
    if (id_pc !== 32'h0 || id_inst !== NOP) begin
      n_fail++; $display("FAIL reset_id got=%h/%h exp=0/%h", id_pc, id_inst, NOP);
    end
  endtask

  task automatic test_basic();
    rst = 0; ce = 1; pc = 32'h0; imem_gnt = 1;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || stallreq_if !== 1'b1) begin
      n_fail++; $display("FAIL basic_req got req=%0b addr=%h sreq=%0b exp 1/0/1", imem_req, imem_addr, stallreq_if);
    end
    cyc();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h2402_0001;
    #1;
    n_checks++;
    if (stallreq_if !== 1'b0) begin n_fail++; $display("FAIL basic_sreq_low got=%0b exp=0", stallreq_if); end
    cyc();
    imem_rvalid = 0;
    n_checks++;
    if (id_pc !== 32'h0 || id_inst !== 32'h2402_0001) begin
      n_fail++; $display("FAIL basic_load got=%h/%h exp=0/24020001", id_pc, id_inst);
    end
  endtask

  task automatic test_latency();
    int high_cnt = 0;
    pc = 32'h4; imem_gnt = 1;
    #1; if (stallreq_if) high_cnt++;
    cyc();
    imem_gnt = 0;
    for (int i = 0; i < 2; i++) begin
      #1; if (stallreq_if) high_cnt++;
      cyc();
    end
    imem_rvalid = 1; imem_rdata = 32'h8C41_0004;
    #1;
    n_checks++;
    if (high_cnt != 3 || stallreq_if !== 1'b0) begin
      n_fail++; $display("FAIL latency_sreq got high=%0d last=%0b exp 3/0", high_cnt, stallreq_if);
    end
    cyc();
    imem_rvalid = 0;
    n_checks++;
    if (id_pc !== 32'h4 || id_inst !== 32'h8C41_0004) begin
      n_fail++; $display("FAIL latency_load got=%h/%h exp=4/8c410004", id_pc, id_inst);
    end
    cyc();
    n_checks++;
    if (id_inst !== NOP || id_pc !== 32'h0) begin
      n_fail++; $display("FAIL latency_once got=%h/%h exp=0/%h", id_pc, id_inst, NOP);
    end
  endtask

  task automatic test_hold();
    pc = 32'h8; imem_gnt = 1;
    cyc();
    imem_gnt = 0; stall = 6'b000011; imem_rvalid = 1; imem_rdata = 32'h2063_0008;
    #1;
    n_checks++;
    if (stallreq_if !== 1'b1) begin n_fail++; $display("FAIL hold_sreq got=%0b exp=1", stallreq_if); end
    cyc();
    n_checks++;
    if (id_pc !== 32'h0 || id_inst !== NOP) begin
      n_fail++; $display("FAIL hold_bubble got=%h/%h exp=0/%h", id_pc, id_inst, NOP);
    end
    imem_rvalid = 0; stall = 0;
    #1;
    n_checks++;
    if (stallreq_if !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL hold_release got sreq=%0b req=%0b exp 0/0", stallreq_if, imem_req);
    end
    cyc();
    n_checks++;
    if (id_pc !== 32'h8 || id_inst !== 32'h2063_0008 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL hold_load got=%h/%h req=%0b exp=8/20630008 req=1", id_pc, id_inst, imem_req);
    end
  endtask

  task automatic test_stall_hold();
    pc = 32'hC; imem_gnt = 1;
    cyc();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hAC22_000C;
    cyc();
    imem_rvalid = 0; stall = 6'b000111;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++;
      if (id_pc !== 32'hC || id_inst !== 32'hAC22_000C) begin
        n_fail++; $display("FAIL stall_hold[%0d] got=%h/%h exp=c/ac22000c", i, id_pc, id_inst);
      end
    end
    stall = 0;
    cyc();
  endtask

  task automatic test_flush();
    pc = 32'h10; imem_gnt = 1;
    cyc();
    imem_gnt = 0; flush = 1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flush_req got=%0b exp=0", imem_req); end
    cyc();
    flush = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || stallreq_if !== 1'b1) begin
      n_fail++; $display("FAIL flush_drop got req=%0b sreq=%0b exp 0/1", imem_req, stallreq_if);
    end
    cyc();
    imem_rvalid = 0;
    n_checks++;
    if (id_inst !== NOP || id_pc !== 32'h0) begin
      n_fail++; $display("FAIL flush_discard got=%h/%h exp=0/%h", id_pc, id_inst, NOP);
    end
    imem_gnt = 1;
    cyc();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h3C01_0010;
    cyc();
    imem_rvalid = 0;
    n_checks++;
    if (id_pc !== 32'h10 || id_inst !== 32'h3C01_0010) begin
      n_fail++; $display("FAIL flush_refetch got=%h/%h exp=10/3c010010", id_pc, id_inst);
    end
    pc = 32'h14; imem_gnt = 1;
    cyc();
    imem_gnt = 0; stall = 6'b000011; imem_rvalid = 1; imem_rdata = 32'h1111_0014;
    cyc();
    imem_rvalid = 0; stall = 0; flush = 1;
    #1;
    n_checks++;
    if (stallreq_if !== 1'b1) begin n_fail++; $display("FAIL flush_hold_sreq got=%0b exp=1", stallreq_if); end
    cyc();
    flush = 0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL flush_hold_idle got req=%0b exp=1", imem_req); end
    cyc();
    n_checks++;
    if (id_inst !== NOP || id_pc !== 32'h0) begin
      n_fail++; $display("FAIL flush_hold_nodup got=%h/%h exp=0/%h", id_pc, id_inst, NOP);
    end
  endtask

  task automatic test_reset_midfetch();
    pc = 32'h18; imem_gnt = 1;
    cyc();
    imem_gnt = 0; rst = 1;
    cyc();
    rst = 0; ce = 0; imem_rvalid = 1; imem_rdata = 32'h5555_0018;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || stallreq_if !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_comb got req=%0b sreq=%0b exp 0/0", imem_req, stallreq_if);
    end
    cyc();
    imem_rvalid = 0; ce = 1;
    #1;
    n_checks++;
    if (id_inst !== NOP || id_pc !== 32'h0 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_ignore got=%h/%h req=%0b exp=0/%h req=1", id_pc, id_inst, imem_req, NOP);
    end
  endtask

  task automatic test_random();
    logic [31:0] dpc, dinst;
    bit exp_req, exp_sreq;
    rst = 1; ce = 0; flush = 0; stall = 0; imem_gnt = 0; imem_rvalid = 0;
    cyc(); cyc();
    rst = 0;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      ce = ($urandom_range(0, 7) != 0);
      imem_gnt = $urandom_range(0, 1);
      imem_rvalid = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        5: stall = 6'b000011;
        6: stall = 6'b000111;
        7: stall = 6'b000101;
        default: stall = 6'b000000;
      endcase
      pc = $urandom & 32'hFFFF_FFFC;
      imem_rdata = $urandom;
      #1;
      exp_req = model_idle() && ce && !flush;
      exp_sreq = ce && !model_delivers(dpc, dinst);
      n_checks++;
      if (imem_req !== exp_req || stallreq_if !== exp_sreq || (exp_req && imem_addr !== pc)) begin
        n_fail++;
        $display("FAIL rand_comb[%0d] got req=%0b sreq=%0b addr=%h exp req=%0b sreq=%0b addr=%h",
                 i, imem_req, stallreq_if, imem_addr, exp_req, exp_sreq, pc);
      end
      @(posedge clk);
      model_clock();
      #1;
      n_checks++;
      if (id_pc !== m_id_pc || id_inst !== m_id_inst) begin
        n_fail++;
        $display("FAIL rand_id[%0d] got=%h/%h exp=%h/%h", i, id_pc, id_inst, m_id_pc, m_id_inst);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_hold();
    test_stall_hold();
    test_flush();
    test_reset_midfetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
